// File: rtl/vga_draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vga_draw_sequencer
// Purpose  : Shares one VGA plot bus among NUM_CH draw engines. It grants one
//            requesting channel at a time, runs that engine's start/waitrequest
//            handshake, muxes the engine's plot/x/y/colour onto the adapter
//            bus, and reports a done or watchdog-timeout pulse per channel.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req[NUM_CH]         - level draw requests from the controller
//            grant[NUM_CH]       - one-hot bus owner, 0 when idle
//            ch_start[NUM_CH]    - start to engine, held until accepted
//            ch_waitrequest      - engine busy / not accepting
//            ch_plot/x/y/colour  - packed engine plot buses (channel i at i*W)
//            done, timeout_err   - one-cycle completion / abort pulses
//            busy                - sequencer not idle
//            vga_plot/x/y/colour - muxed bus to the vga_adapter
// Revision : 1.0 - initial release
// ============================================================================
module vga_draw_sequencer #(
    parameter int NUM_CH   = 4,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int C_W      = 3,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     req,
    output logic [NUM_CH-1:0]     grant,
    output logic [NUM_CH-1:0]     ch_start,
    input  logic [NUM_CH-1:0]     ch_waitrequest,
    input  logic [NUM_CH-1:0]     ch_plot,
    input  logic [NUM_CH*X_W-1:0] ch_x,
    input  logic [NUM_CH*Y_W-1:0] ch_y,
    input  logic [NUM_CH*C_W-1:0] ch_colour,
    output logic [NUM_CH-1:0]     done,
    output logic [NUM_CH-1:0]     timeout_err,
    output logic                  busy,
    output logic                  vga_plot,
    output logic [X_W-1:0]        vga_x,
    output logic [Y_W-1:0]        vga_y,
    output logic [C_W-1:0]        vga_colour
);

    localparam int C_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int C_WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [C_WD_W-1:0] C_WD_LIMIT = C_WD_W'(TIMEOUT);
    localparam logic [NUM_CH-1:0] C_ONE      = NUM_CH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GUARD = 2'd2,
        S_DRAW  = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic [NUM_CH-1:0]   grant_q,    grant_d;
    logic [NUM_CH-1:0]   start_q,    start_d;
    logic [NUM_CH-1:0]   done_q,     done_d;
    logic [NUM_CH-1:0]   to_q,       to_d;
    logic [C_IDX_W-1:0]  rr_ptr_q,   rr_ptr_d;
    logic [C_WD_W-1:0]   wd_cnt_q,   wd_cnt_d;

    logic [C_IDX_W-1:0]  w_arb_idx;
    logic                w_arb_found;
    int                  w_rr_cand;
    logic [C_WD_W-1:0]   w_wd_next;
    logic                w_wd_expire;
    logic                w_accept;
    logic                w_eng_free;

    // ------------------------------------------------------------------
    // Arbiter. Loops run from the far end so the last hit (the winner)
    // is the lowest index / the first candidate after rr_ptr.
    // ------------------------------------------------------------------
    always_comb begin
        w_arb_idx   = '0;
        w_arb_found = 1'b0;
        w_rr_cand   = 0;
        if (ARB_MODE == 0) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    w_arb_idx   = C_IDX_W'(i);
                    w_arb_found = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_CH; k >= 1; k--) begin
                w_rr_cand = (int'(rr_ptr_q) + k) % NUM_CH;
                if (req[w_rr_cand]) begin
                    w_arb_idx   = C_IDX_W'(w_rr_cand);
                    w_arb_found = 1'b1;
                end
            end
        end
    end

    // Watchdog: saturating count of active cycles; expiry when this
    // cycle brings the count to TIMEOUT.
    always_comb begin
        w_wd_next   = (wd_cnt_q == C_WD_LIMIT) ? wd_cnt_q : wd_cnt_q + 1'b1;
        w_wd_expire = (TIMEOUT != 0) && (state_q != S_IDLE) && (w_wd_next == C_WD_LIMIT);
    end

    assign w_accept   = |(start_q & ~ch_waitrequest);
    assign w_eng_free = |(grant_q & ~ch_waitrequest);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        start_d  = start_q;
        rr_ptr_d = rr_ptr_q;
        done_d   = '0;
        to_d     = '0;
        wd_cnt_d = (state_q == S_IDLE) ? '0 : w_wd_next;

        unique case (state_q)
            S_IDLE: begin
                if (w_arb_found) begin
                    grant_d = C_ONE << w_arb_idx;
                    start_d = C_ONE << w_arb_idx;
                    if (ARB_MODE != 0) begin
                        rr_ptr_d = w_arb_idx;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_wd_expire) begin
                    start_d = '0;
                    grant_d = '0;
                    to_d    = grant_q;
                    state_d = S_IDLE;
                end else if (w_accept) begin
                    start_d = '0;
                    state_d = S_GUARD;
                end
            end
            S_GUARD: begin
                // Waitrequest is stale here: the engine is still registering
                // its busy flag after the accept edge.
                if (w_wd_expire) begin
                    grant_d = '0;
                    to_d    = grant_q;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                // Completion takes priority over a coincident watchdog expiry.
                if (w_eng_free) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    state_d = S_IDLE;
                end else if (w_wd_expire) begin
                    grant_d = '0;
                    to_d    = grant_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                start_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            start_q  <= '0;
            done_q   <= '0;
            to_q     <= '0;
            rr_ptr_q <= C_IDX_W'(NUM_CH - 1);
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            start_q  <= start_d;
            done_q   <= done_d;
            to_q     <= to_d;
            rr_ptr_q <= rr_ptr_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The bus mux is combinational on the one-hot grant so only
    // the owner's plot strobe can ever reach the adapter.
    // ------------------------------------------------------------------
    assign grant       = grant_q;
    assign ch_start    = start_q;
    assign done        = done_q;
    assign timeout_err = to_q;
    assign busy        = (state_q != S_IDLE);

    always_comb begin
        vga_plot   = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        if (state_q != S_IDLE) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (grant_q[i]) begin
                    vga_plot   = ch_plot[i];
                    vga_x      = ch_x[i*X_W +: X_W];
                    vga_y      = ch_y[i*Y_W +: Y_W];
                    vga_colour = ch_colour[i*C_W +: C_W];
                end
            end
        end
    end

endmodule
`default_nettype wire
